// File: rtl/pad_cfg_pkg.sv
// Shared types and defaults for the pad configuration sequencer and its per-side banks.
package pad_cfg_pkg;

   localparam int NPADS_DEF = 9;
   localparam int CFGW_DEF  = 8;
   localparam int PAD_W     = 4;

   typedef enum logic [1:0] {
      SIDE_NO = 2'd0,
      SIDE_SO = 2'd1,
      SIDE_EA = 2'd2,
      SIDE_WE = 2'd3
   } side_e;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_INIT = 2'd1,
      ST_IDLE = 2'd2
   } state_e;

endpackage

// File: rtl/pad_cfg_bank.sv
// One padring side: cfg/ie/oen registers with an indexed write port and,
// under PAD_CFG_READBACK_EN, an indexed read mux.
module pad_cfg_bank
   import pad_cfg_pkg::*;
#(
   parameter int NPADS = NPADS_DEF,
   parameter int CFGW  = CFGW_DEF
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  we,
   input  logic [PAD_W-1:0]      idx,
   input  logic [CFGW-1:0]       cfg_in,
   input  logic                  ie_in,
   input  logic                  oen_in,
   output logic [NPADS*CFGW-1:0] cfg,
   output logic [NPADS-1:0]      ie,
   output logic [NPADS-1:0]      oen
`ifdef PAD_CFG_READBACK_EN
   ,
   output logic [CFGW-1:0]       rd_cfg,
   output logic                  rd_ie,
   output logic                  rd_oen
`endif
);

   logic [NPADS*CFGW-1:0] cfg_q, cfg_d;
   logic [NPADS-1:0]      ie_q, ie_d;
   logic [NPADS-1:0]      oen_q, oen_d;

   always_comb begin
      cfg_d = cfg_q;
      ie_d  = ie_q;
      oen_d = oen_q;
      for (int k = 0; k < NPADS; k++) begin
         if (we && (32'(idx) == k)) begin
            cfg_d[k*CFGW +: CFGW] = cfg_in;
            ie_d[k]               = ie_in;
            oen_d[k]              = oen_in;
         end
      end
   end

   // Safe pad state: outputs disabled (oen high), inputs off, config cleared.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cfg_q <= '0;
         ie_q  <= '0;
         oen_q <= '1;
      end else begin
         cfg_q <= cfg_d;
         ie_q  <= ie_d;
         oen_q <= oen_d;
      end
   end

   assign cfg = cfg_q;
   assign ie  = ie_q;
   assign oen = oen_q;

`ifdef PAD_CFG_READBACK_EN
   always_comb begin
      rd_cfg = '0;
      rd_ie  = 1'b0;
      rd_oen = 1'b0;
      for (int k = 0; k < NPADS; k++) begin
         if (32'(idx) == k) begin
            rd_cfg = cfg_q[k*CFGW +: CFGW];
            rd_ie  = ie_q[k];
            rd_oen = oen_q[k];
         end
      end
   end
`endif

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Padring bring-up sequencer and single-requester config write port.
// Optional pad readback is enabled with the PAD_CFG_READBACK_EN macro.
module pad_cfg_sequencer
   import pad_cfg_pkg::*;
#(
   parameter int              NPADS   = NPADS_DEF,
   parameter int              CFGW    = CFGW_DEF,
   parameter int              SETTLE  = 16,
   parameter logic [CFGW-1:0] DEF_CFG = '0
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_side,
   input  logic [PAD_W-1:0]      req_pad,
   input  logic [CFGW-1:0]       req_cfg,
   input  logic                  req_ie,
   input  logic                  req_oen,
   output logic                  err,
   input  logic                  err_clr,
`ifdef PAD_CFG_READBACK_EN
   input  logic                  req_write,
   output logic                  rsp_valid,
   output logic [CFGW-1:0]       rsp_cfg,
   output logic                  rsp_ie,
   output logic                  rsp_oen,
`endif
   output logic                  init_done,
   output logic [NPADS*CFGW-1:0] no_cfg,
   output logic [NPADS*CFGW-1:0] so_cfg,
   output logic [NPADS*CFGW-1:0] ea_cfg,
   output logic [NPADS*CFGW-1:0] we_cfg,
   output logic [NPADS-1:0]      no_ie,
   output logic [NPADS-1:0]      so_ie,
   output logic [NPADS-1:0]      ea_ie,
   output logic [NPADS-1:0]      we_ie,
   output logic [NPADS-1:0]      no_oen,
   output logic [NPADS-1:0]      so_oen,
   output logic [NPADS-1:0]      ea_oen,
   output logic [NPADS-1:0]      we_oen
);

   localparam int               SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int               CNT_W      = $clog2(SETTLE_EFF + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE_EFF - 1);
   localparam logic [PAD_W-1:0] IDX_LAST   = PAD_W'(NPADS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PAD_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;

   logic             init_we, hs, is_wr, pad_oob, wr_en, err_evt;
   logic [3:0]       bank_we;
   logic [PAD_W-1:0] bank_idx;
   logic [CFGW-1:0]  bank_cfg;
   logic             bank_ie, bank_oen;

   logic [NPADS*CFGW-1:0] side_cfg [4];
   logic [NPADS-1:0]      side_ie  [4];
   logic [NPADS-1:0]      side_oen [4];

`ifdef PAD_CFG_READBACK_EN
   logic            rsp_valid_q, rsp_valid_d;
   logic [CFGW-1:0] rsp_cfg_q, rsp_cfg_d;
   logic            rsp_ie_q, rsp_ie_d;
   logic            rsp_oen_q, rsp_oen_d;
   logic [CFGW-1:0] side_rd_cfg [4];
   logic [3:0]      side_rd_ie, side_rd_oen;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      init_we = 1'b0;
      case (state_q)
         ST_HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_INIT;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         ST_INIT: begin
            init_we = 1'b1;
            if (idx_q == IDX_LAST) state_d = ST_IDLE;
            else                   idx_d   = idx_q + 1'b1;
         end
         ST_IDLE: ;
         default: state_d = ST_HOLD;
      endcase
   end

   // Handshake: a request transfers on a rising edge where req_valid && req_ready.
   // req_ready is a pure decode of the IDLE state; the requester keeps req_valid
   // high with stable fields until that edge, and nothing is accepted in HOLD/INIT.
   assign req_ready = (state_q == ST_IDLE);
   assign init_done = (state_q == ST_IDLE);
   assign hs        = req_valid && req_ready;
   assign pad_oob   = (32'(req_pad) >= NPADS);
   assign wr_en     = hs && is_wr && !pad_oob;
   assign err_evt   = hs && pad_oob;

   // INIT owns all four banks at the init index; otherwise the request drives them.
   always_comb begin
      bank_we  = '0;
      bank_idx = req_pad;
      bank_cfg = req_cfg;
      bank_ie  = req_ie;
      bank_oen = req_oen;
      if (init_we) begin
         bank_we  = 4'b1111;
         bank_idx = idx_q;
         bank_cfg = DEF_CFG;
         bank_ie  = 1'b1;
         bank_oen = 1'b1;
      end else begin
         for (int s = 0; s < 4; s++) bank_we[s] = wr_en && (req_side == 2'(s));
      end
   end

   always_comb begin
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (err_evt) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;

   for (genvar s = 0; s < 4; s++) begin : g_bank
      pad_cfg_bank #(
         .NPADS (NPADS),
         .CFGW  (CFGW)
      ) u_bank (
         .clk    (clk),
         .nreset (nreset),
         .we     (bank_we[s]),
         .idx    (bank_idx),
         .cfg_in (bank_cfg),
         .ie_in  (bank_ie),
         .oen_in (bank_oen),
         .cfg    (side_cfg[s]),
         .ie     (side_ie[s]),
         .oen    (side_oen[s])
`ifdef PAD_CFG_READBACK_EN
         ,
         .rd_cfg (side_rd_cfg[s]),
         .rd_ie  (side_rd_ie[s]),
         .rd_oen (side_rd_oen[s])
`endif
      );
   end

   assign no_cfg = side_cfg[SIDE_NO];
   assign so_cfg = side_cfg[SIDE_SO];
   assign ea_cfg = side_cfg[SIDE_EA];
   assign we_cfg = side_cfg[SIDE_WE];
   assign no_ie  = side_ie[SIDE_NO];
   assign so_ie  = side_ie[SIDE_SO];
   assign ea_ie  = side_ie[SIDE_EA];
   assign we_ie  = side_ie[SIDE_WE];
   assign no_oen = side_oen[SIDE_NO];
   assign so_oen = side_oen[SIDE_SO];
   assign ea_oen = side_oen[SIDE_EA];
   assign we_oen = side_oen[SIDE_WE];

`ifdef PAD_CFG_READBACK_EN
   assign is_wr = req_write;

   // Out-of-range reads answer all-zero rather than the safe-state pattern.
   always_comb begin
      rsp_valid_d = hs && !req_write;
      rsp_cfg_d   = rsp_cfg_q;
      rsp_ie_d    = rsp_ie_q;
      rsp_oen_d   = rsp_oen_q;
      if (rsp_valid_d) begin
         if (pad_oob) begin
            rsp_cfg_d = '0;
            rsp_ie_d  = 1'b0;
            rsp_oen_d = 1'b0;
         end else begin
            rsp_cfg_d = side_rd_cfg[req_side];
            rsp_ie_d  = side_rd_ie[req_side];
            rsp_oen_d = side_rd_oen[req_side];
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rsp_valid_q <= 1'b0;
         rsp_cfg_q   <= '0;
         rsp_ie_q    <= 1'b0;
         rsp_oen_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_cfg_q   <= rsp_cfg_d;
         rsp_ie_q    <= rsp_ie_d;
         rsp_oen_q   <= rsp_oen_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_cfg   = rsp_cfg_q;
   assign rsp_ie    = rsp_ie_q;
   assign rsp_oen   = rsp_oen_q;
`else
   assign is_wr = 1'b1;
`endif

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: bring-up timing, writes, errors and async reset.
// DEF_CFG is overridden to a non-zero value so the init load is observable.
module tb_pad_cfg_sequencer;

   localparam int               NP      = 9;
   localparam int               CW      = 8;
   localparam logic [CW-1:0]    DEF     = 8'h5A;
   localparam logic [NP*CW-1:0] DEF_VEC = {NP{DEF}};

   logic          clk = 1'b0;
   logic          nreset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [1:0]    req_side = '0;
   logic [3:0]    req_pad = '0;
   logic [CW-1:0] req_cfg = '0;
   logic          req_ie = 1'b0;
   logic          req_oen = 1'b0;
   logic          err;
   logic          err_clr = 1'b0;
   logic          req_write = 1'b1;
   logic          init_done;
   logic [NP*CW-1:0] no_cfg, so_cfg, ea_cfg, we_cfg;
   logic [NP-1:0]    no_ie, so_ie, ea_ie, we_ie;
   logic [NP-1:0]    no_oen, so_oen, ea_oen, we_oen;
`ifdef PAD_CFG_READBACK_EN
   logic          rsp_valid;
   logic [CW-1:0] rsp_cfg;
   logic          rsp_ie, rsp_oen;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pad_cfg_sequencer #(
      .NPADS   (NP),
      .CFGW    (CW),
      .SETTLE  (16),
      .DEF_CFG (DEF)
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_side  (req_side),
      .req_pad   (req_pad),
      .req_cfg   (req_cfg),
      .req_ie    (req_ie),
      .req_oen   (req_oen),
      .err       (err),
      .err_clr   (err_clr),
`ifdef PAD_CFG_READBACK_EN
      .req_write (req_write),
      .rsp_valid (rsp_valid),
      .rsp_cfg   (rsp_cfg),
      .rsp_ie    (rsp_ie),
      .rsp_oen   (rsp_oen),
`endif
      .init_done (init_done),
      .no_cfg    (no_cfg),
      .so_cfg    (so_cfg),
      .ea_cfg    (ea_cfg),
      .we_cfg    (we_cfg),
      .no_ie     (no_ie),
      .so_ie     (so_ie),
      .ea_ie     (ea_ie),
      .we_ie     (we_ie),
      .no_oen    (no_oen),
      .so_oen    (so_oen),
      .ea_oen    (ea_oen),
      .we_oen    (we_oen)
   );

   // Driver: present a request; caller is at a negedge.
   task automatic drive_req(input logic [1:0] side, input logic [3:0] pad,
                            input logic [CW-1:0] cfg, input logic ie, input logic oen,
                            input logic wr);
      req_side  = side;
      req_pad   = pad;
      req_cfg   = cfg;
      req_ie    = ie;
      req_oen   = oen;
      req_write = wr;
      req_valid = 1'b1;
   endtask

   // Driver: release reset at a negedge and count edges until req_ready is seen (bounded).
   task automatic release_and_wait(output int cyc);
      @(negedge clk);
      nreset = 1'b1;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (req_ready) break;
      end
   endtask

   task automatic test_reset();
      int cyc;
      nreset = 1'b0;
      #12;
      checks++;
      if ({no_cfg, so_cfg, ea_cfg, we_cfg} !== '0) begin
         errors++; $display("FAIL reset_cfg: got %h want 0", {no_cfg, so_cfg, ea_cfg, we_cfg});
      end
      checks++;
      if ({no_ie, so_ie, ea_ie, we_ie} !== 36'h0) begin
         errors++; $display("FAIL reset_ie: got %h want 0", {no_ie, so_ie, ea_ie, we_ie});
      end
      checks++;
      if ({no_oen, so_oen, ea_oen, we_oen} !== 36'hF_FFFF_FFFF) begin
         errors++; $display("FAIL reset_oen: got %h want fffffffff", {no_oen, so_oen, ea_oen, we_oen});
      end
      checks++;
      if ({req_ready, err, init_done} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got %b want 000", {req_ready, err, init_done});
      end
      @(negedge clk);
      nreset = 1'b1;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         checks++;
         if ({no_oen, so_oen, ea_oen, we_oen} !== 36'hF_FFFF_FFFF) begin
            errors++; $display("FAIL bringup_oen c%0d: got %h want fffffffff", cyc, {no_oen, so_oen, ea_oen, we_oen});
         end
         if (cyc <= 16) begin
            checks++;
            if ({no_ie, so_ie, ea_ie, we_ie} !== 36'h0) begin
               errors++; $display("FAIL hold_ie c%0d: got %h want 0", cyc, {no_ie, so_ie, ea_ie, we_ie});
            end
         end
         if (req_ready) break;
      end
      checks++;
      if (cyc !== 25) begin
         errors++; $display("FAIL bringup_cycles: got %0d want 25", cyc);
      end
      checks++;
      if ({no_cfg, so_cfg, ea_cfg, we_cfg} !== {4{DEF_VEC}}) begin
         errors++; $display("FAIL init_cfg: got %h want %h", {no_cfg, so_cfg, ea_cfg, we_cfg}, {4{DEF_VEC}});
      end
      checks++;
      if ({no_ie, so_ie, ea_ie, we_ie} !== 36'hF_FFFF_FFFF) begin
         errors++; $display("FAIL init_ie: got %h want fffffffff", {no_ie, so_ie, ea_ie, we_ie});
      end
      checks++;
      if ({init_done, err} !== 2'b10) begin
         errors++; $display("FAIL init_done: got %b want 10", {init_done, err});
      end
   endtask

   task automatic test_write();
      logic [NP*CW-1:0] exp_ea;
      exp_ea = DEF_VEC;
      exp_ea[39:32] = 8'hA5;
      drive_req(2'd2, 4'd4, 8'hA5, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (ea_cfg !== exp_ea) begin
         errors++; $display("FAIL write_ea_cfg: got %h want %h", ea_cfg, exp_ea);
      end
      checks++;
      if ({ea_ie, ea_oen} !== {9'h1FF, 9'h1EF}) begin
         errors++; $display("FAIL write_ea_ie_oen: got %h want %h", {ea_ie, ea_oen}, {9'h1FF, 9'h1EF});
      end
      checks++;
      if ({no_cfg, so_cfg, we_cfg} !== {3{DEF_VEC}}) begin
         errors++; $display("FAIL write_others_cfg: got %h want %h", {no_cfg, so_cfg, we_cfg}, {3{DEF_VEC}});
      end
      checks++;
      if ({no_ie, so_ie, we_ie, no_oen, so_oen, we_oen} !== 54'h3F_FFFF_FFFF_FFFF) begin
         errors++; $display("FAIL write_others_ie_oen: got %h want all ones", {no_ie, so_ie, we_ie, no_oen, so_oen, we_oen});
      end
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] got;
      for (int i = 0; i < NP; i++) begin
         drive_req(2'd3, 4'(i), 8'(i + 1), 1'b1, 1'b1, 1'b1);
         checks++;
         if (req_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready p%0d: got %b want 1", i, req_ready);
         end
         @(negedge clk);
         got = we_cfg[i*CW +: CW];
         checks++;
         if (got !== 8'(i + 1)) begin
            errors++; $display("FAIL b2b_latency p%0d: got %h want %h", i, got, 8'(i + 1));
         end
      end
      req_valid = 1'b0;
      checks++;
      if (we_cfg !== 72'h090807060504030201) begin
         errors++; $display("FAIL b2b_we_cfg: got %h want 090807060504030201", we_cfg);
      end
      checks++;
      if ({we_ie, we_oen, ea_oen} !== {9'h1FF, 9'h1FF, 9'h1EF}) begin
         errors++; $display("FAIL b2b_ie_oen: got %h want %h", {we_ie, we_oen, ea_oen}, {9'h1FF, 9'h1FF, 9'h1EF});
      end
   endtask

   task automatic test_error();
      drive_req(2'd0, 4'd12, 8'hFF, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_set: got %b want 1", err);
      end
      checks++;
      if ({no_cfg, no_ie, no_oen} !== {DEF_VEC, 9'h1FF, 9'h1FF}) begin
         errors++; $display("FAIL err_dropped: got %h want %h", {no_cfg, no_ie, no_oen}, {DEF_VEC, 9'h1FF, 9'h1FF});
      end
      drive_req(2'd0, 4'd15, 8'hFF, 1'b0, 1'b0, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_wins_clr: got %b want 1", err);
      end
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clr: got %b want 0", err);
      end
      checks++;
      if (no_cfg !== DEF_VEC) begin
         errors++; $display("FAIL err_no_cfg: got %h want %h", no_cfg, DEF_VEC);
      end
   endtask

   task automatic test_hold_valid();
      int cyc;
      logic [NP*CW-1:0] exp_so;
      exp_so = DEF_VEC;
      exp_so[23:16] = 8'h77;
      @(negedge clk);
      nreset = 1'b0;
      #1;
      drive_req(2'd1, 4'd2, 8'h77, 1'b0, 1'b0, 1'b1);
      release_and_wait(cyc);
      checks++;
      if (cyc !== 25) begin
         errors++; $display("FAIL hold_first_ready: got %0d want 25", cyc);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({so_cfg, so_ie, so_oen} !== {exp_so, 9'h1FB, 9'h1FB}) begin
         errors++; $display("FAIL hold_accept: got %h want %h", {so_cfg, so_ie, so_oen}, {exp_so, 9'h1FB, 9'h1FB});
      end
      checks++;
      if ({no_cfg, ea_cfg, we_cfg} !== {3{DEF_VEC}}) begin
         errors++; $display("FAIL hold_others: got %h want %h", {no_cfg, ea_cfg, we_cfg}, {3{DEF_VEC}});
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      @(negedge clk);
      nreset = 1'b0;
      #2;
      @(negedge clk);
      nreset = 1'b1;
      repeat (20) @(posedge clk);
      #3;
      nreset = 1'b0;
      #1;
      checks++;
      if ({no_cfg, so_cfg, ea_cfg, we_cfg, no_ie, so_ie, ea_ie, we_ie} !== '0) begin
         errors++; $display("FAIL async_init_zero: got %h want 0", {no_cfg, so_cfg, ea_cfg, we_cfg, no_ie, so_ie, ea_ie, we_ie});
      end
      checks++;
      if ({no_oen, so_oen, ea_oen, we_oen, req_ready, init_done} !== {36'hF_FFFF_FFFF, 2'b00}) begin
         errors++; $display("FAIL async_init_oen: got %h want %h", {no_oen, so_oen, ea_oen, we_oen, req_ready, init_done}, {36'hF_FFFF_FFFF, 2'b00});
      end
      release_and_wait(cyc);
      checks++;
      if (cyc !== 25) begin
         errors++; $display("FAIL async_init_rerun: got %0d want 25", cyc);
      end
      drive_req(2'd2, 4'd0, 8'h11, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive_req(2'd0, 4'd13, 8'h22, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({err, ea_cfg[7:0], ea_ie[0]} !== {1'b1, 8'h11, 1'b0}) begin
         errors++; $display("FAIL idle_precond: got %h want %h", {err, ea_cfg[7:0], ea_ie[0]}, {1'b1, 8'h11, 1'b0});
      end
      @(posedge clk);
      #3;
      nreset = 1'b0;
      #1;
      checks++;
      if ({no_cfg, so_cfg, ea_cfg, we_cfg, no_ie, so_ie, ea_ie, we_ie} !== '0) begin
         errors++; $display("FAIL async_idle_zero: got %h want 0", {no_cfg, so_cfg, ea_cfg, we_cfg, no_ie, so_ie, ea_ie, we_ie});
      end
      checks++;
      if ({no_oen, so_oen, ea_oen, we_oen, req_ready, init_done, err} !== {36'hF_FFFF_FFFF, 3'b000}) begin
         errors++; $display("FAIL async_idle_flags: got %h want %h", {no_oen, so_oen, ea_oen, we_oen, req_ready, init_done, err}, {36'hF_FFFF_FFFF, 3'b000});
      end
      release_and_wait(cyc);
      checks++;
      if (cyc !== 25) begin
         errors++; $display("FAIL async_idle_rerun: got %0d want 25", cyc);
      end
      checks++;
      if ({no_cfg, so_cfg, ea_cfg, we_cfg} !== {4{DEF_VEC}}) begin
         errors++; $display("FAIL async_idle_reload: got %h want %h", {no_cfg, so_cfg, ea_cfg, we_cfg}, {4{DEF_VEC}});
      end
   endtask

`ifdef PAD_CFG_READBACK_EN
   task automatic test_readback();
      drive_req(2'd2, 4'd4, 8'hC3, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      drive_req(2'd2, 4'd4, 8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_cfg, rsp_ie, rsp_oen} !== {1'b1, 8'hC3, 1'b1, 1'b0}) begin
         errors++; $display("FAIL rd_resp: got %h want %h", {rsp_valid, rsp_cfg, rsp_ie, rsp_oen}, {1'b1, 8'hC3, 1'b1, 1'b0});
      end
      checks++;
      if (ea_cfg[39:32] !== 8'hC3) begin
         errors++; $display("FAIL rd_no_modify: got %h want c3", ea_cfg[39:32]);
      end
      drive_req(2'd1, 4'd9, 8'h00, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_cfg, rsp_ie, rsp_oen, err} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL rd_oob: got %h want %h", {rsp_valid, rsp_cfg, rsp_ie, rsp_oen, err}, {1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rd_pulse: got %b want 0", rsp_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_error();
      test_hold_valid();
      test_async_reset();
`ifdef PAD_CFG_READBACK_EN
      test_readback();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
